bcd_updown_counter: RTL and testbench

//  Parametrised N-digit BCD (decade) up/down counter: async clear, sync clear, parallel load,

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_digit_cell.sv | 52 +++++
 rtl/bcd_updown_counter.sv | 59 +++++
 tb/tb_bcd_updown_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit limits, nibble type and validity helpers.
package bcd_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t     BCD_MAX    = 4'd9;
    localparam nibble_t     BCD_MIN    = 4'd0;
    localparam int unsigned MAX_DIGITS = 8;

    // True when the nibble is a legal decimal digit.
    function automatic logic bcd_valid(input nibble_t n);
        return n <= BCD_MAX;
    endfunction

    // True when the low 'digits' nibbles of a word are all legal decimal digits.
    function automatic logic bcd_word_valid(input logic [31:0] val, input int unsigned digits);
        logic ok;
        ok = 1'b1;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if (k < digits && !bcd_valid(val[4*k +: 4])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // One decimal step with wrap; only meaningful for a valid digit.
    function automatic nibble_t bcd_step(input nibble_t n, input logic up);
        nibble_t r;
        if (up) begin
            r = (n == BCD_MAX) ? BCD_MIN : n + 4'd1;
        end else begin
            r = (n == BCD_MIN) ? BCD_MAX : n - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: nibble register, clear/load/step next-value logic and carry out.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cin_i,
    input  logic       up_i,
    input  logic       ld_i,
    input  logic       sclr_i,
    input  logic [3:0] d_i,
    input  logic [3:0] rst_nibble_i,
    output logic [3:0] q_o,
    output logic       cout_o,
    output logic       bad_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       terminal;

    // Next digit value: clear beats load beats step; cin already carries the count qualifier.
    always_comb begin
        q_d = q_q;
        if (sclr_i) begin
            q_d = rst_nibble_i;
        end else if (ld_i) begin
            q_d = d_i;
        end else if (cin_i) begin
            q_d = bcd_step(q_q, up_i);
        end
    end

    // Terminal digit for the current direction: 9 going up, 0 going down.
    always_comb begin
        terminal = up_i ? (q_q == BCD_MAX) : (q_q == BCD_MIN);
    end

    // Digit register; rst_nibble_i is a tie-off constant from the top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= rst_nibble_i;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign cout_o = cin_i & terminal;
    assign bad_o  = ~bcd_valid(q_q);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable N-digit BCD up/down counter with clear, load, enable and carry chain.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned             DIGITS  = 2,
    parameter logic [4*DIGITS-1:0]     RST_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclr_i,
    input  logic                  ld_i,
    input  logic                  en_i,
    input  logic                  cai_i,
    input  logic                  up_i,
    input  logic [4*DIGITS-1:0]   d_i,
    output logic [4*DIGITS-1:0]   q_o,
    output logic                  cao_o,
    output logic                  err_o
);

    localparam int unsigned W = 4 * DIGITS;

    // Elaboration-time guards on the parameters.
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_updown_counter: DIGITS must be 1..8");
    end
    if (!bcd_word_valid(32'(RST_VAL), DIGITS)) begin : g_bad_rst_val
        $error("bcd_updown_counter: RST_VAL must be valid BCD");
    end

    // carry[k] is the step request into digit k; carry[0] is the qualified count enable.
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] bad;
    logic [W-1:0]      q;

    assign err_o    = |bad;
    assign carry[0] = en_i & cai_i & ~err_o;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .cin_i       (carry[k]),
            .up_i        (up_i),
            .ld_i        (ld_i),
            .sclr_i      (sclr_i),
            .d_i         (d_i[4*k +: 4]),
            .rst_nibble_i(RST_VAL[4*k +: 4]),
            .q_o         (q[4*k +: 4]),
            .cout_o      (carry[k+1]),
            .bad_o       (bad[k])
        );
    end

    // Carry leaving the top digit is exactly the cascade output: all digits terminal and enabled.
    assign cao_o = carry[DIGITS];
    assign q_o   = q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: decimal reference model, per-cycle compare, directed literal checks.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sclr, ld, en, cai, up;
    logic [7:0] d, q;
    logic       cao, err;

    logic        c_sclr, c_ld, c_en, c_up;
    logic [15:0] c_d;
    logic [7:0]  lo_q, hi_q;
    logic        lo_cao, hi_cao, lo_err, hi_err;

    int checks = 0;
    int errors = 0;

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sclr_i(sclr), .ld_i(ld), .en_i(en), .cai_i(cai),
        .up_i(up), .d_i(d), .q_o(q), .cao_o(cao), .err_o(err)
    );

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_lo (
        .clk_i(clk), .rst_ni(rst_n), .sclr_i(c_sclr), .ld_i(c_ld), .en_i(c_en), .cai_i(1'b1),
        .up_i(c_up), .d_i(c_d[7:0]), .q_o(lo_q), .cao_o(lo_cao), .err_o(lo_err)
    );

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_hi (
        .clk_i(clk), .rst_ni(rst_n), .sclr_i(c_sclr), .ld_i(c_ld), .en_i(c_en), .cai_i(lo_cao),
        .up_i(c_up), .d_i(c_d[15:8]), .q_o(hi_q), .cao_o(hi_cao), .err_o(hi_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec2(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic int dec4(input logic [15:0] v);
        return dec2(v[15:8]) * 100 + dec2(v[7:0]);
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] bcd4(input int v);
        return {bcd2(v / 100), bcd2(v % 100)};
    endfunction

    function automatic logic nonbcd(input logic [7:0] v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    // Reference: main counter as raw byte (may hold garbage), cascade as an integer 0..9999.
    logic [7:0] m_q;
    int         c_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= 8'h00;
            c_m <= 0;
        end else begin
            if (sclr)                              m_q <= 8'h00;
            else if (ld)                           m_q <= d;
            else if (en && cai && !nonbcd(m_q))    m_q <= bcd2((dec2(m_q) + (up ? 1 : 99)) % 100);
            if (c_sclr)     c_m <= 0;
            else if (c_ld)  c_m <= dec4(c_d);
            else if (c_en)  c_m <= (c_m + (c_up ? 1 : 9999)) % 10000;
        end
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        chk("q", 32'(q), 32'(m_q));
        chk("err", 32'(err), 32'(nonbcd(m_q)));
        chk("cao", 32'(cao),
            32'(en && cai && !nonbcd(m_q) && (up ? dec2(m_q) == 99 : dec2(m_q) == 0)));
        chk("casc_q", 32'({hi_q, lo_q}), 32'(bcd4(c_m)));
        chk("casc_cao", 32'(hi_cao), 32'(c_en && (c_up ? c_m == 9999 : c_m == 0)));
        chk("casc_err", 32'(lo_err | hi_err), 32'(0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int pick;

    initial begin
        rst_n = 1'b0;
        sclr = 0; ld = 0; en = 1; cai = 1; up = 1; d = 8'h00;
        c_sclr = 0; c_ld = 0; c_en = 0; c_up = 1; c_d = 16'h0000;

        // Reset state and CAO during reset.
        #1;
        chk("t1_q", 32'(q), 32'h00);
        chk("t1_err", 32'(err), 32'h0);
        chk("t1_cao_up", 32'(cao), 32'h0);
        up = 0;
        #1;
        chk("t1_cao_dn", 32'(cao), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 0;

        // Up through wrap.
        cyc(); ld = 1; d = 8'h98; up = 1; en = 1; cai = 1;
        cyc(); ld = 0; #1;
        chk("t2_load", 32'(q), 32'h98); chk("t2_cao98", 32'(cao), 32'h0);
        cyc(); chk("t2_99", 32'(q), 32'h99); chk("t2_cao99", 32'(cao), 32'h1);
        cyc(); chk("t2_00", 32'(q), 32'h00); chk("t2_cao00", 32'(cao), 32'h0);
        cyc(); chk("t2_01", 32'(q), 32'h01);

        // Down through wrap.
        cyc(); ld = 1; d = 8'h01; up = 0;
        cyc(); ld = 0; #1;
        chk("t3_load", 32'(q), 32'h01); chk("t3_cao01", 32'(cao), 32'h0);
        cyc(); chk("t3_00", 32'(q), 32'h00); chk("t3_cao00", 32'(cao), 32'h1);
        cyc(); chk("t3_99", 32'(q), 32'h99); chk("t3_cao99", 32'(cao), 32'h0);
        cyc(); chk("t3_98", 32'(q), 32'h98);

        // CAI gating, digit carry, enable hold.
        cyc(); ld = 1; d = 8'h19; up = 1; cai = 0;
        cyc(); ld = 0; #1; chk("t4_load", 32'(q), 32'h19);
        cyc(); chk("t4_cai0", 32'(q), 32'h19);
        cai = 1;
        cyc(); chk("t4_carry", 32'(q), 32'h20);
        en = 0;
        cyc(); chk("t4_hold", 32'(q), 32'h20);

        // Non-BCD load sticks until clear.
        cyc(); ld = 1; d = 8'h3A; en = 1; cai = 1;
        cyc(); ld = 0; #1;
        chk("t5_q", 32'(q), 32'h3A); chk("t5_err", 32'(err), 32'h1); chk("t5_cao", 32'(cao), 32'h0);
        repeat (4) cyc();
        chk("t5_stuck", 32'(q), 32'h3A);
        sclr = 1;
        cyc(); sclr = 0; #1;
        chk("t5_clr", 32'(q), 32'h00); chk("t5_err0", 32'(err), 32'h0);

        // Cascade ripple, async reset mid-count, SCLR beats LD.
        cyc(); c_ld = 1; c_d = 16'h0099; c_up = 1; c_en = 1; up = 1;
        cyc(); c_ld = 0; #1;
        chk("t6_0099", 32'({hi_q, lo_q}), 32'h0099); chk("t6_locao", 32'(lo_cao), 32'h1);
        cyc(); chk("t6_0100", 32'({hi_q, lo_q}), 32'h0100);
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_q", 32'(q), 32'h00); chk("t6_rst_casc", 32'({hi_q, lo_q}), 32'h0000);
        rst_n = 1'b1;
        cyc(); ld = 1; sclr = 1; d = 8'h55;
        cyc(); ld = 0; sclr = 0; #1;
        chk("t6_sclr_ld", 32'(q), 32'h00);

        // Randomised phase, checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            sclr = ($urandom_range(0, 31) == 0);
            ld   = ($urandom_range(0, 15) == 0);
            pick = $urandom_range(0, 3);
            if (pick == 0)      d = 8'($urandom);
            else if (pick == 1) d = bcd2($urandom_range(95, 99));
            else if (pick == 2) d = bcd2($urandom_range(0, 4));
            else                d = bcd2($urandom_range(0, 99));
            en  = ($urandom_range(0, 3) != 0);
            cai = ($urandom_range(0, 3) != 0);
            up  = ($urandom_range(0, 1) == 1);

            c_sclr = ($urandom_range(0, 127) == 0);
            c_ld   = ($urandom_range(0, 31) == 0);
            pick = $urandom_range(0, 2);
            if (pick == 0)      c_d = bcd4($urandom_range(9980, 9999));
            else if (pick == 1) c_d = bcd4($urandom_range(0, 19));
            else                c_d = bcd4($urandom_range(0, 9999));
            c_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) c_up = ~c_up;
        end

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
